// File: rtl/adpcm_pkg.sv
// rtl/adpcm_pkg.sv - shared constants, step-size ROM and state type for the IMA-ADPCM decoder
package adpcm_pkg;

  localparam int STEP_IDX_MAX = 88;

  // Index delta per code magnitude (code[2:0]); the sign bit never affects it.
  localparam logic signed [7:0] INDEX_ADJ [0:7] = '{
    -8'sd1, -8'sd1, -8'sd1, -8'sd1, 8'sd2, 8'sd4, 8'sd6, 8'sd8
  };

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } state_e;

  function automatic logic [15:0] step_table(input logic [6:0] idx);
    logic [15:0] s;
    case (idx)
      7'd0:  s = 16'd7;      7'd1:  s = 16'd8;
      7'd2:  s = 16'd9;      7'd3:  s = 16'd10;
      7'd4:  s = 16'd11;     7'd5:  s = 16'd12;
      7'd6:  s = 16'd13;     7'd7:  s = 16'd14;
      7'd8:  s = 16'd16;     7'd9:  s = 16'd17;
      7'd10: s = 16'd19;     7'd11: s = 16'd21;
      7'd12: s = 16'd23;     7'd13: s = 16'd25;
      7'd14: s = 16'd28;     7'd15: s = 16'd31;
      7'd16: s = 16'd34;     7'd17: s = 16'd37;
      7'd18: s = 16'd41;     7'd19: s = 16'd45;
      7'd20: s = 16'd50;     7'd21: s = 16'd55;
      7'd22: s = 16'd60;     7'd23: s = 16'd66;
      7'd24: s = 16'd73;     7'd25: s = 16'd80;
      7'd26: s = 16'd88;     7'd27: s = 16'd97;
      7'd28: s = 16'd107;    7'd29: s = 16'd118;
      7'd30: s = 16'd130;    7'd31: s = 16'd143;
      7'd32: s = 16'd157;    7'd33: s = 16'd173;
      7'd34: s = 16'd190;    7'd35: s = 16'd209;
      7'd36: s = 16'd230;    7'd37: s = 16'd253;
      7'd38: s = 16'd279;    7'd39: s = 16'd307;
      7'd40: s = 16'd337;    7'd41: s = 16'd371;
      7'd42: s = 16'd408;    7'd43: s = 16'd449;
      7'd44: s = 16'd494;    7'd45: s = 16'd544;
      7'd46: s = 16'd598;    7'd47: s = 16'd658;
      7'd48: s = 16'd724;    7'd49: s = 16'd796;
      7'd50: s = 16'd876;    7'd51: s = 16'd963;
      7'd52: s = 16'd1060;   7'd53: s = 16'd1166;
      7'd54: s = 16'd1282;   7'd55: s = 16'd1411;
      7'd56: s = 16'd1552;   7'd57: s = 16'd1707;
      7'd58: s = 16'd1878;   7'd59: s = 16'd2066;
      7'd60: s = 16'd2272;   7'd61: s = 16'd2499;
      7'd62: s = 16'd2749;   7'd63: s = 16'd3024;
      7'd64: s = 16'd3327;   7'd65: s = 16'd3660;
      7'd66: s = 16'd4026;   7'd67: s = 16'd4428;
      7'd68: s = 16'd4871;   7'd69: s = 16'd5358;
      7'd70: s = 16'd5894;   7'd71: s = 16'd6484;
      7'd72: s = 16'd7132;   7'd73: s = 16'd7845;
      7'd74: s = 16'd8630;   7'd75: s = 16'd9493;
      7'd76: s = 16'd10442;  7'd77: s = 16'd11487;
      7'd78: s = 16'd12635;  7'd79: s = 16'd13899;
      7'd80: s = 16'd15289;  7'd81: s = 16'd16818;
      7'd82: s = 16'd18500;  7'd83: s = 16'd20350;
      7'd84: s = 16'd22385;  7'd85: s = 16'd24623;
      7'd86: s = 16'd27086;  7'd87: s = 16'd29794;
      default: s = 16'd32767;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/inverse_quantizer.sv
// rtl/inverse_quantizer.sv - combinational IMA-ADPCM reconstruction of one sample from a 4-bit code
module inverse_quantizer (
  input  logic signed [15:0] prev_predicted,
  input  logic [3:0]         code,
  input  logic [15:0]        step_size,
  output logic signed [15:0] predicted
);

  logic [17:0]        diff;
  logic signed [17:0] sum;

  always_comb begin
    diff = {5'd0, step_size[15:3]};
    if (code[2]) diff = diff + {2'd0, step_size};
    if (code[1]) diff = diff + {3'd0, step_size[15:1]};
    if (code[0]) diff = diff + {4'd0, step_size[15:2]};

    // diff never exceeds 2^17, so it is safe to treat as signed here
    if (code[3]) sum = {{2{prev_predicted[15]}}, prev_predicted} - $signed(diff);
    else         sum = {{2{prev_predicted[15]}}, prev_predicted} + $signed(diff);

    if (sum > 18'sd32767)       predicted = 16'sh7fff;
    else if (sum < -18'sd32768) predicted = 16'sh8000;
    else                        predicted = sum[15:0];
  end

endmodule

// File: rtl/adpcm_decode_sequencer.sv
// rtl/adpcm_decode_sequencer.sv - byte-fed IMA-ADPCM decoder: nibble sequencing, predictor/index state, output register
module adpcm_decode_sequencer
  import adpcm_pkg::*;
#(
  parameter bit LOW_NIBBLE_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_valid,
  input  logic [15:0] init_sample,
  input  logic [6:0]  init_index,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sample
);

  state_e             state_q, state_d;
  logic signed [15:0] pred_q, pred_d;
  logic [6:0]         index_q, index_d;
  logic [7:0]         byte_q, byte_d;
  logic               out_valid_q, out_valid_d;
  logic [15:0]        out_sample_q, out_sample_d;

  logic               slot_free;
  logic               decode;
  logic [3:0]         code;
  logic [15:0]        step;
  logic signed [15:0] predicted;
  logic signed [7:0]  adj_sum;
  logic [6:0]         next_index;

  inverse_quantizer u_iq (
    .prev_predicted (pred_q),
    .code           (code),
    .step_size      (step),
    .predicted      (predicted)
  );

  always_comb begin
    state_d      = state_q;
    pred_d       = pred_q;
    index_d      = index_q;
    byte_d       = byte_q;
    out_valid_d  = out_valid_q;
    out_sample_d = out_sample_q;
    in_ready     = 1'b0;
    decode       = 1'b0;

    slot_free = !out_valid_q || out_ready;

    if ((state_q == ST_FIRST) == LOW_NIBBLE_FIRST) code = byte_q[3:0];
    else                                           code = byte_q[7:4];

    step    = step_table(index_q);
    adj_sum = $signed({1'b0, index_q}) + INDEX_ADJ[code[2:0]];
    if (adj_sum < 8'sd0)                  next_index = 7'd0;
    else if (adj_sum > 8'(STEP_IDX_MAX))  next_index = 7'(STEP_IDX_MAX);
    else                                  next_index = adj_sum[6:0];

    if (init_valid) begin
      // Header load wins: pending nibbles are abandoned, the output register is left alone
      pred_d  = pred_q;
      pred_d  = $signed(init_sample);
      index_d = (init_index > 7'(STEP_IDX_MAX)) ? 7'(STEP_IDX_MAX) : init_index;
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          in_ready = 1'b1;
          if (in_valid) begin
            byte_d  = in_data;
            state_d = ST_FIRST;
          end
        end
        ST_FIRST: begin
          if (slot_free) begin
            decode  = 1'b1;
            state_d = ST_SECOND;
          end
        end
        ST_SECOND: begin
          if (slot_free) begin
            decode   = 1'b1;
            in_ready = 1'b1;
            if (in_valid) begin
              byte_d  = in_data;
              state_d = ST_FIRST;
            end else begin
              state_d = ST_FETCH;
            end
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end

    if (decode) begin
      pred_d       = predicted;
      index_d      = next_index;
      out_sample_d = predicted;
      out_valid_d  = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      pred_q       <= '0;
      index_q      <= '0;
      byte_q       <= '0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
    end else begin
      state_q      <= state_d;
      pred_q       <= pred_d;
      index_q      <= index_d;
      byte_q       <= byte_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;

endmodule

// File: tb/tb_adpcm_decode_sequencer.sv
// tb/tb_adpcm_decode_sequencer.sv - self-checking bench for adpcm_decode_sequencer against a nibble-queue model
module tb_adpcm_decode_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_valid;
  logic [15:0] init_sample;
  logic [6:0]  init_index;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sample;

  adpcm_decode_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_valid  (init_valid),
    .init_sample (init_sample),
    .init_index  (init_index),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sample  (out_sample)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int step_tab [89] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
    253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963,
    1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327,
    3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487,
    12635, 13899, 15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767};
  int adj_tab [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

  // Model state: nibbles waiting to be decoded, predictor, index, output register
  int m_pend[$];
  int m_pred, m_idx, m_os;
  bit m_ov;
  bit m_live = 1'b0;

  int got[$];
  int got_cyc[$];
  int exp_lit[$];
  int cyc = 0;
  logic [7:0] tx_q[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_in_ready();
    if (init_valid) return 1'b0;
    return (m_pend.size() == 0) || (m_pend.size() == 1 && (!m_ov || out_ready));
  endfunction

  task automatic model_decode(input int nib);
    int step, diff, p;
    step = step_tab[m_idx];
    diff = step / 8;
    if (nib & 4) diff += step;
    if (nib & 2) diff += step / 2;
    if (nib & 1) diff += step / 4;
    p = (nib & 8) ? m_pred - diff : m_pred + diff;
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    m_pred = p;
    m_os   = p;
    m_ov   = 1'b1;
    m_idx  = m_idx + adj_tab[nib & 7];
    if (m_idx < 0) m_idx = 0;
    if (m_idx > 88) m_idx = 88;
  endtask

  always @(posedge clk) begin
    bit acc, free;
    int b;
    cyc++;
    if (rst_n && out_valid && out_ready) begin
      got.push_back(int'($signed(out_sample)));
      got_cyc.push_back(cyc);
    end
    if (!rst_n) begin
      m_pend.delete();
      m_pred = 0; m_idx = 0; m_ov = 1'b0; m_os = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      acc  = model_in_ready() && in_valid;
      free = !m_ov || out_ready;
      if (init_valid) begin
        m_pend.delete();
        m_pred = int'($signed(init_sample));
        m_idx  = (init_index > 88) ? 88 : int'(init_index);
        if (out_ready) m_ov = 1'b0;
      end else begin
        if (m_pend.size() > 0 && free) model_decode(m_pend.pop_front());
        else if (out_ready) m_ov = 1'b0;
        if (acc) begin
          b = int'(in_data);
          m_pend.push_back(b & 15);
          m_pend.push_back(b >> 4);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", int'(in_ready), int'(model_in_ready()));
      chk("out_valid", int'(out_valid), int'(m_ov));
      chk("out_sample", int'($signed(out_sample)), m_os);
    end
  end

  int saw_ir, saw_ir2, saw_ov, saw_os;

  task automatic run_stream(input int ncyc, input int stall_at, input int stall_len,
                            input int init_at, input int isamp, input int iidx, input int rst_at);
    for (int c = 0; c < ncyc; c++) begin
      in_valid    = tx_q.size() > 0;
      in_data     = in_valid ? tx_q[0] : 8'($urandom);
      out_ready   = !(c >= stall_at && c < stall_at + stall_len);
      init_valid  = (c == init_at);
      init_sample = 16'(isamp);
      init_index  = 7'(iidx);
      rst_n       = (c != rst_at);
      @(negedge clk);
      if (c == init_at) saw_ir = int'(in_ready);
      if (c == init_at + 1) saw_ir2 = int'(in_ready);
      if (c == rst_at + 1) begin
        saw_ov = int'(out_valid); saw_os = int'(out_sample); saw_ir = int'(in_ready);
      end
      if (in_valid && in_ready && rst_n && !init_valid) void'(tx_q.pop_front());
      @(posedge clk); #1;
    end
    in_valid = 1'b0; init_valid = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
    chk("tx_drained", tx_q.size(), 0);
    tx_q.delete();
  endtask

  task automatic do_init(input int s, input int i);
    tx_q.delete();
    run_stream(2, -1, 0, 0, s, i, -1);
    got.delete();
    got_cyc.delete();
  endtask

  task automatic chk_got(input string name);
    chk({name, "_count"}, got.size(), exp_lit.size());
    for (int i = 0; i < exp_lit.size() && i < got.size(); i++)
      chk(name, got[i], exp_lit[i]);
  endtask

  initial begin
    rst_n = 1'b0; init_valid = 1'b0; init_sample = '0; init_index = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_sample", int'(out_sample), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;

    do_init(0, 0);
    tx_q = '{8'h07};
    run_stream(6, -1, 0, -1, 0, 0, -1);
    exp_lit = '{11, 13};
    chk_got("basic");
    chk("basic_idx", m_idx, 7);
    if (got_cyc.size() == 2) chk("basic_back_to_back", got_cyc[1] - got_cyc[0], 1);
    else chk("basic_back_to_back", got_cyc.size(), 2);

    do_init(-32760, 88);
    tx_q = '{8'h88};
    run_stream(6, -1, 0, -1, 0, 0, -1);
    exp_lit = '{-32768, -32768};
    chk_got("neg_clamp");
    chk("neg_clamp_idx", m_idx, 86);

    do_init(0, 0);
    tx_q = '{8'h00, 8'h00};
    run_stream(8, -1, 0, -1, 0, 0, -1);
    exp_lit = '{0, 0, 0, 0};
    chk_got("idx_floor");
    chk("idx_floor_idx", m_idx, 0);

    do_init(0, 0);
    tx_q = '{8'h07, 8'h00, 8'h07};
    run_stream(16, 3, 5, -1, 0, 0, -1);
    exp_lit = '{11, 13, 14, 15, 37, 40};
    chk_got("backpressure");

    do_init(0, 0);
    tx_q = '{8'h77, 8'h08};
    run_stream(8, -1, 0, 1, 1000, 120, -1);
    chk("init_in_ready", saw_ir, 0);
    chk("init_then_fetch", saw_ir2, 1);
    exp_lit = '{-3095, 629};
    chk_got("init_priority");
    chk("init_idx", m_idx, 86);

    do_init(0, 0);
    tx_q = '{8'h07, 8'h07};
    run_stream(8, -1, 0, -1, 0, 0, 2);
    chk("rst_out_valid", saw_ov, 0);
    chk("rst_out_sample", saw_os, 0);
    chk("rst_in_ready", saw_ir, 1);
    exp_lit = '{11, 13};
    chk_got("after_reset");

    for (int c = 0; c < 600; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_data     = 8'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      init_valid  = ($urandom_range(0, 31) == 0);
      init_sample = 16'($urandom);
      init_index  = 7'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; init_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
